alu_cmd_dispatch: RTL and testbench



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/alu_cmd_dispatch.sv | 157 +++++++++++++++
 tb/tb_alu_cmd_dispatch.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM states and opcode helpers for the ALU16 command front-end.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_SHL   = 4'b0100;
  localparam logic [3:0] OP_SHR   = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_XNOR  = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1000;
  localparam logic [3:0] OP_AND   = 4'b1001;
  localparam logic [3:0] OP_OR    = 4'b1010;
  localparam logic [3:0] OP_BOOTH = 4'b1011;
  localparam logic [3:0] OP_NRDIV = 4'b1100;

  // Wide enough for any latency below 256 cycles.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] op_latency(input logic [3:0] op,
                                                  input int lat_simple,
                                                  input int lat_mul,
                                                  input int lat_div);
    if (op == OP_BOOTH)      return lat_mul[CNT_W-1:0];
    else if (op == OP_NRDIV) return lat_div[CNT_W-1:0];
    else                     return lat_simple[CNT_W-1:0];
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_NRDIV;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: registered storage, no bypass, pointers wrap modulo DEPTH.
module alu_cmd_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/alu_cmd_dispatch.sv
// Feeds ALU16 from a command FIFO, holds operands for the op latency and returns the result.
module alu_cmd_dispatch
  import alu_pkg::*;
#(
  parameter int W          = 16,
  parameter int DEPTH      = 4,
  parameter int LAT_SIMPLE = 1,
  parameter int LAT_MUL    = 17,
  parameter int LAT_DIV    = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [3:0]   cmd_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_zero,
  output logic [3:0]   res_op,
  output logic         res_err
);

  localparam int FW = 2*W + 4;

  logic [FW-1:0] fifo_dout;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [W-1:0]  head_a, head_b;
  logic [3:0]    head_op;
  logic          head_screened;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              res_valid_q, res_valid_d;
  logic [W-1:0]      res_data_q, res_data_d;
  logic              res_zero_q, res_zero_d, res_err_q, res_err_d;
  logic [3:0]        res_op_q, res_op_d;

  assign cmd_ready = !fifo_full && !reset;
  assign fifo_push = cmd_valid && cmd_ready;

  alu_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({cmd_op, cmd_a, cmd_b}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_op = fifo_dout[FW-1 -: 4];
  assign head_a  = fifo_dout[2*W-1 -: W];
  assign head_b  = fifo_dout[W-1:0];
  // Illegal opcodes and zero divisors never reach the ALU.
  assign head_screened = !op_legal(head_op) ||
                         (((head_op == OP_DIV) || (head_op == OP_NRDIV)) && (head_b == '0));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_err_d   = res_err_q;
    res_op_d    = res_op_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_screened) begin
            res_data_d  = '1;
            res_zero_d  = 1'b0;
            res_err_d   = 1'b1;
            res_op_d    = head_op;
            res_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            alu_op_d = head_op;
            cnt_d    = op_latency(head_op, LAT_SIMPLE, LAT_MUL, LAT_DIV);
            state_d  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_data_d  = alu_out;
          res_zero_d  = alu_zero;
          res_op_d    = alu_op_q;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      res_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_err_q   <= res_err_d;
      res_op_q    <= res_op_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_err   = res_err_q;
  assign res_op    = res_op_q;

endmodule

// File: tb/tb_alu_cmd_dispatch.sv
// Bench for alu_cmd_dispatch: ALU16 stand-in, result scoreboard, directed cases then random traffic.
module tb_alu_cmd_dispatch;
  import alu_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic         cmd_valid, cmd_ready;
  logic [W-1:0] cmd_a, cmd_b;
  logic [3:0]   cmd_op;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [3:0]   alu_op;
  logic         alu_zero;
  logic         res_valid, res_ready, res_zero, res_err;
  logic [W-1:0] res_data;
  logic [3:0]   res_op;

  alu_cmd_dispatch dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_op    (res_op),
    .res_err   (res_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU behaviour
  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
    logic signed [31:0] p;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL, OP_BOOTH: begin
        p = $signed(a) * $signed(b);
        return p[15:0];
      end
      OP_DIV, OP_NRDIV: begin
        if (b == 16'h0) return 16'hFFFF;
        if (a == 16'h8000 && b == 16'hFFFF) return 16'h8000;
        return 16'($signed(a) / $signed(b));
      end
      OP_SHL:  return a << b[3:0];
      OP_SHR:  return a >> b[3:0];
      OP_XOR:  return a ^ b;
      OP_XNOR: return ~(a ^ b);
      OP_NOT:  return ~a;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return 16'hFFFF;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (op == OP_BOOTH || op == OP_NRDIV) ? 17 : 1;
  endfunction

  // ALU stand-in: output is only correct once operands have been held for the op latency.
  int age = 100;
  logic [15:0] alu_exact;
  always_comb begin
    alu_exact = ref_alu(alu_a, alu_b, alu_op);
    alu_out   = (age >= lat_of(alu_op) - 1) ? alu_exact : (alu_exact ^ 16'h5A5A);
    alu_zero  = (alu_out == 16'h0);
  end

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] data;
    logic        zero;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  function automatic exp_t make_exp(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    exp_t e;
    logic scr;
    scr = (op > 4'b1100) || (((op == OP_DIV) || (op == OP_NRDIV)) && b == 16'h0);
    e.a = a; e.b = b; e.op = op;
    e.err  = scr;
    e.data = scr ? 16'hFFFF : ref_alu(a, b, op);
    e.zero = scr ? 1'b0 : (e.data == 16'h0);
    return e;
  endfunction

  // scoreboard / compare process
  logic [35:0] prev_alu = '0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  int          issue_cyc = 0;
  logic [15:0] last_a = '0, last_b = '0;
  logic [3:0]  last_op = '0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      last_a = '0; last_b = '0; last_op = '0;
      check("reset_outputs",
            {alu_a, alu_b, alu_op, res_valid, res_data, res_zero, res_err, res_op, cmd_ready}, '0);
      prev_alu   = {alu_a, alu_b, alu_op};
      age        = 100;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if ({alu_a, alu_b, alu_op} != prev_alu) begin
        issue_cyc = cyc;
        age       = 0;
      end else if (age < 1000) begin
        age++;
      end
      prev_alu = {alu_a, alu_b, alu_op};
      if (res_valid && !prev_valid && !res_err)
        check("latency", 64'(cyc - issue_cyc), 64'(lat_of(res_op)));
      if (prev_valid && !prev_ready) check("hold_valid", res_valid, 1'b1);
      if (exp_q.size() <= DEPTH - 1)      check("cmd_ready_open", cmd_ready, 1'b1);
      else if (exp_q.size() >= DEPTH + 1) check("cmd_ready_full", cmd_ready, 1'b0);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1'b1, 1'b0);
        end else begin
          e = exp_q[0];
          check("res_data", res_data, e.data);
          check("res_zero", res_zero, e.zero);
          check("res_err", res_err, e.err);
          check("res_op", res_op, e.op);
          if (e.err) check("alu_hold", {alu_a, alu_b, alu_op}, {last_a, last_b, last_op});
          else       check("alu_drive", {alu_a, alu_b, alu_op}, {e.a, e.b, e.op});
          if (res_ready) begin
            void'(exp_q.pop_front());
            if (!e.err) begin
              last_a = e.a; last_b = e.b; last_op = e.op;
            end
          end
        end
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(make_exp(cmd_a, cmd_b, cmd_op));
      prev_valid = res_valid;
      prev_ready = res_ready;
    end
  end

  // driver tasks
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                      input int max_cyc, output bit ok);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  bit          ok, rv, stable, done;
  int          cnt, accepted;
  logic [15:0] ra, rb, sa, sb;
  logic [3:0]  rop, sop;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);

    check("model_add", ref_alu(16'hFDEF, 16'd10, OP_ADD), 16'hFDF9);
    check("model_booth", ref_alu(16'd30, 16'd40, OP_BOOTH), 16'd1200);
    check("model_sub", ref_alu(16'd1245, 16'd433, OP_SUB), 16'd812);

    // single add
    step();
    res_ready = 1'b1;
    send(16'hFDEF, 16'd10, OP_ADD, 10, ok);
    check("add_accept", ok, 1'b1);
    wait_valid(30, ok);
    check("add_seen", ok, 1'b1);
    check("add_data", res_data, 16'hFDF9);
    check("add_flags", {res_zero, res_err}, 2'b00);
    step();

    // Booth latency and operand stability
    send(16'd30, 16'd40, OP_BOOTH, 10, ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (alu_op == OP_BOOTH) break;
    end
    cnt = 0; stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      stable &= ({alu_a, alu_b, alu_op} == {16'd30, 16'd40, OP_BOOTH});
      if (res_valid) break;
    end
    check("booth_latency", cnt, 17);
    check("booth_stable", stable, 1'b1);
    check("booth_data", res_data, 16'd1200);
    step();

    // screened divide-by-zero and illegal opcode
    send(16'd80, 16'd0, OP_NRDIV, 10, ok);
    wait_valid(30, ok);
    check("div0_seen", ok, 1'b1);
    check("div0_result", {res_data, res_err, res_op}, {16'hFFFF, 1'b1, OP_NRDIV});
    check("div0_alu_held", {alu_a, alu_b, alu_op}, {16'd30, 16'd40, OP_BOOTH});
    step();
    send(16'd5, 16'd6, 4'b1110, 10, ok);
    wait_valid(30, ok);
    check("illegal_result", {res_data, res_err, res_op}, {16'hFFFF, 1'b1, 4'b1110});
    step();

    // zero flag
    send(16'd3, 16'd3, OP_SUB, 10, ok);
    wait_valid(30, ok);
    check("zero_result", {res_data, res_zero, res_err}, {16'h0, 1'b1, 1'b0});
    step();

    // backpressure
    res_ready = 1'b0;
    accepted  = 0;
    send(16'd1245, 16'd433, OP_SUB, 20, ok);
    if (ok) accepted++;
    for (int i = 0; i < 5; i++) begin
      sa = 16'($urandom); sb = 16'($urandom);
      sop = OP_AND + 4'($urandom_range(0, 1));
      send(sa, sb, sop, 20, ok);
      if (ok) accepted++;
    end
    check("bp_accepted", accepted, 5);
    @(negedge clk);
    check("bp_ready_low", cmd_ready, 1'b0);
    step();
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_first", res_data, 16'd812);
    step();
    send(sa, sb, sop, 40, ok);
    check("bp_last_accept", ok, 1'b1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    check("bp_drain", exp_q.size(), 0);

    // reset in the middle of a division
    send(16'd80, 16'd40, OP_NRDIV, 10, ok);
    repeat (5) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", cmd_ready, 1'b1);
    rv = 1'b0;
    repeat (30) begin
      @(negedge clk);
      rv |= res_valid;
    end
    check("no_result_after_reset", rv, 1'b0);
    step();

    // random traffic with random result backpressure
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          ra  = 16'($urandom);
          rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
          rop = 4'($urandom_range(0, 15));
          send(ra, rb, rop, 200, ok);
          check("rand_accept", ok, 1'b1);
          repeat ($urandom_range(0, 2)) step();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    res_ready = 1'b1;
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) step();
    check("rand_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
